// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width, baud setup
// constants and the arbiter state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int BAUD_RATE   = 115_200;
  localparam int BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: returns the first set request at or
// after the pointer, wrapping around the request vector.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_any
);

  int               w_tmp;
  logic [PTR_W-1:0] w_idx;

  // Walk the requesters starting at the pointer and grant the first one seen
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_tmp   = 0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_tmp = int'(i_ptr) + i;
      if (w_tmp >= N_REQ) begin
        w_tmp = w_tmp - N_REQ;
      end
      w_idx = PTR_W'(w_tmp);
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the single UART TX FIFO between several byte-stream requesters.
// One owner is granted at a time and keeps the FIFO for a whole message,
// ended by its last flag, a burst cap or an idle timeout. The write strobe
// and data are combinational so the FIFO write lines up with the handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  input  logic [N_REQ-1:0]         req_last_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REQ-1:0]         grant_o,
  output logic                     uart_we_o,
  output logic [31:0]              uart_tx_wdata_o,
  input  logic                     uart_tx_full_i,
  output logic                     uart_ce_o,
  output logic                     uart_req_o,
  input  logic                     uart_gnt_i,
  output logic                     timeout_o,
  output logic                     busy_o
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(N_REQ - 1);

  arbState_t         r_state;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_rrPtr;
  logic [BEAT_W-1:0] r_beatCnt;
  logic [IDLE_W-1:0] r_idleCnt;
  logic [N_REQ-1:0]  r_grant;
  logic              r_timeout;

  logic [N_REQ-1:0]       w_pickGrant;
  logic                   w_pickAny;
  logic [IDX_W-1:0]       w_pickIdx;
  logic                   w_busy;
  logic                   w_ownerValid;
  logic                   w_ownerLast;
  logic [UART_DATA_W-1:0] w_ownerByte;
  logic                   w_canSend;
  logic                   w_fire;
  logic                   w_relDone;
  logic                   w_relTimeout;
  logic [IDX_W-1:0]       w_nextPtr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (IDX_W)
  ) u_rrArb (
    .i_req   (req_valid_i),
    .i_ptr   (r_rrPtr),
    .o_grant (w_pickGrant),
    .o_any   (w_pickAny)
  );

  // Convert the one-hot pick into the owner index stored by the FSM
  always_comb begin
    w_pickIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pickGrant[i]) begin
        w_pickIdx = IDX_W'(i);
      end
    end
  end

  assign w_busy       = (r_state == XFER);
  assign w_ownerValid = req_valid_i[r_owner];
  assign w_ownerLast  = req_last_i[r_owner];
  assign w_ownerByte  = req_data_i[int'(r_owner)*UART_DATA_W +: UART_DATA_W];

  // Backpressure (FIFO full or bus not granted) stalls but is not idleness
  assign w_canSend    = ~uart_tx_full_i & uart_gnt_i;
  assign w_fire       = w_busy & w_ownerValid & w_canSend;

  assign w_relDone    = w_fire & (w_ownerLast | (r_beatCnt == BEAT_LAST));
  assign w_relTimeout = w_busy & ~w_ownerValid & (r_idleCnt == IDLE_LAST);
  assign w_nextPtr    = (r_owner == IDX_MAX) ? '0 : r_owner + 1'b1;

  assign grant_o         = r_grant;
  assign busy_o          = w_busy;
  assign timeout_o       = r_timeout;
  assign uart_ce_o       = w_busy;
  assign uart_req_o      = w_busy;
  assign req_ready_o     = (w_busy && w_canSend) ? r_grant : '0;
  assign uart_we_o       = w_fire;
  assign uart_tx_wdata_o = w_fire ? {{(32-UART_DATA_W){1'b0}}, w_ownerByte} : 32'b0;

  // Ownership FSM with message counters, grant and timeout pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_rrPtr   <= '0;
      r_beatCnt <= '0;
      r_idleCnt <= '0;
      r_grant   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pickAny) begin
            r_owner   <= w_pickIdx;
            r_grant   <= w_pickGrant;
            r_beatCnt <= '0;
            r_idleCnt <= '0;
            r_state   <= XFER;
          end
        end
        XFER: begin
          if (w_fire) begin
            r_beatCnt <= r_beatCnt + 1'b1;
            r_idleCnt <= '0;
          end else if (!w_ownerValid && (r_idleCnt != IDLE_MAX)) begin
            r_idleCnt <= r_idleCnt + 1'b1;
          end
          if (w_relDone || w_relTimeout) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_rrPtr <= w_nextPtr;
          end
          if (w_relTimeout) begin
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqValid;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   reqLast;
  logic           txFull;
  logic           uartGnt;
  logic [N-1:0]   reqReady;
  logic [N-1:0]   grant;
  logic           uartWe;
  logic [31:0]    uartWdata;
  logic           uartCe;
  logic           uartReq;
  logic           timeoutPulse;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mState, mOwner, mPtr, mBeat, mIdle, mTimeout;
  logic [N-1:0] eGrant, eReady;
  logic         eWe, eBusy, eTimeout;
  logic [31:0]  eWdata;

  typedef struct {
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic           full, gnt, rst;
    logic [N-1:0]   xGrant, xReady;
    logic           xWe;
    logic [31:0]    xWdata;
    logic           xBusy, xTimeout;
  } vec_t;

  vec_t vecs[$];

  uart_tx_arbiter #(
    .N_REQ     (N),
    .MAX_BURST (MB),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (reqValid),
    .req_data_i      (reqData),
    .req_last_i      (reqLast),
    .req_ready_o     (reqReady),
    .grant_o         (grant),
    .uart_we_o       (uartWe),
    .uart_tx_wdata_o (uartWdata),
    .uart_tx_full_i  (txFull),
    .uart_ce_o       (uartCe),
    .uart_req_o      (uartReq),
    .uart_gnt_i      (uartGnt),
    .timeout_o       (timeoutPulse),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic [N-1:0] v, input logic [8*N-1:0] d,
                                 input logic [N-1:0] l, input logic f, input logic g,
                                 input logic r, input logic [N-1:0] xg, input logic [N-1:0] xr,
                                 input logic xw, input logic [31:0] xd, input logic xb,
                                 input logic xt);
    vec_t t;
    t.valid = v; t.data = d; t.last = l; t.full = f; t.gnt = g; t.rst = r;
    t.xGrant = xg; t.xReady = xr; t.xWe = xw; t.xWdata = xd; t.xBusy = xb; t.xTimeout = xt;
    return t;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let them settle
  task automatic applyStimulus(input logic [N-1:0] v, input logic [8*N-1:0] d,
                               input logic [N-1:0] l, input logic f, input logic g,
                               input logic r);
    @(negedge clk);
    reqValid = v; reqData = d; reqLast = l; txFull = f; uartGnt = g; rst = r;
    #1;
  endtask

  task automatic checkOutput(input logic [N-1:0] xGrant, input logic [N-1:0] xReady,
                             input logic xWe, input logic [31:0] xWdata, input logic xBusy,
                             input logic xTimeout, input string tag);
    checkVal({tag, ".grant"},   grant,        xGrant);
    checkVal({tag, ".ready"},   reqReady,     xReady);
    checkVal({tag, ".we"},      uartWe,       xWe);
    checkVal({tag, ".wdata"},   uartWdata,    xWdata);
    checkVal({tag, ".busy"},    busy,         xBusy);
    checkVal({tag, ".ce"},      uartCe,       xBusy);
    checkVal({tag, ".req"},     uartReq,      xBusy);
    checkVal({tag, ".timeout"}, timeoutPulse, xTimeout);
  endtask

  // Expected outputs for the current model state and applied inputs
  task automatic modelOutputs();
    eBusy  = (mState == 1);
    eGrant = '0;
    if (mState == 1) eGrant[mOwner] = 1'b1;
    eReady = (mState == 1 && !txFull && uartGnt) ? eGrant : '0;
    eWe    = (mState == 1) && reqValid[mOwner] && !txFull && uartGnt;
    eWdata = eWe ? {24'h0, reqData[mOwner*8 +: 8]} : 32'h0;
    eTimeout = (mTimeout != 0);
  endtask

  // Advance the model by one clock using the arbitration rules
  task automatic stepModel();
    bit release_;
    int k;
    if (rst) begin
      mState = 0; mOwner = 0; mPtr = 0; mBeat = 0; mIdle = 0; mTimeout = 0;
    end else if (mState == 0) begin
      mTimeout = 0;
      for (int i = 0; i < N; i++) begin
        k = (mPtr + i) % N;
        if (mState == 0 && reqValid[k]) begin
          mOwner = k; mState = 1; mBeat = 0; mIdle = 0;
        end
      end
    end else begin
      mTimeout = 0;
      release_ = 0;
      if (eWe) begin
        if (reqLast[mOwner] || mBeat == MB - 1) release_ = 1;
        mBeat++;
        mIdle = 0;
      end else if (!reqValid[mOwner]) begin
        if (mIdle == TO - 1) begin
          release_ = 1;
          mTimeout = 1;
        end else if (mIdle < TO) begin
          mIdle++;
        end
      end
      if (release_) begin
        mState = 0;
        mPtr = (mOwner + 1) % N;
      end
    end
  endtask

  task automatic runCycle(input string tag, input bit doCheck);
    modelOutputs();
    if (doCheck) checkOutput(eGrant, eReady, eWe, eWdata, eBusy, eTimeout, tag);
    @(posedge clk);
    stepModel();
  endtask

  task automatic doReset();
    applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
    runCycle("reset", 1);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int sent, run1, total, gap, phase, idx, pulses, tCycle, gCycle, ownerNow;
    logic [7:0] pData [N];
    logic [N-1:0] pLast, pValid;
    logic [8*N-1:0] dBus;
    bit f, g, r, fired;

    mState = 0; mOwner = 0; mPtr = 0; mBeat = 0; mIdle = 0; mTimeout = 0;
    reqValid = '0; reqData = '0; reqLast = '0; txFull = 0; uartGnt = 1; rst = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, '0, 1'b0, 1'b1, 1'b1);
      runCycle("pre", 0);
    end

    // Directed vectors: "HI" from req0, then req0/req2 contention and wrap
    vecs.push_back(mkVec(4'b0000, 32'h0,         4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0001, 32'h48,        4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0001, 32'h48,        4'b0000, 0, 1, 0, 4'b0001, 4'b0001, 1, 32'h48, 1, 0));
    vecs.push_back(mkVec(4'b0001, 32'h49,        4'b0001, 0, 1, 0, 4'b0001, 4'b0001, 1, 32'h49, 1, 0));
    vecs.push_back(mkVec(4'b0000, 32'h0,         4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0000, 32'h0,         4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0101, 32'h00C0_00A0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0101, 32'h00C0_00A0, 4'b0000, 0, 1, 0, 4'b0001, 4'b0001, 1, 32'hA0, 1, 0));
    vecs.push_back(mkVec(4'b0101, 32'h00C0_00A1, 4'b0000, 0, 1, 0, 4'b0001, 4'b0001, 1, 32'hA1, 1, 0));
    vecs.push_back(mkVec(4'b0101, 32'h00C0_00A2, 4'b0001, 0, 1, 0, 4'b0001, 4'b0001, 1, 32'hA2, 1, 0));
    vecs.push_back(mkVec(4'b0100, 32'h00C0_0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0100, 32'h00C0_0000, 4'b0000, 0, 1, 0, 4'b0100, 4'b0100, 1, 32'hC0, 1, 0));
    vecs.push_back(mkVec(4'b0100, 32'h00C1_0000, 4'b0000, 0, 1, 0, 4'b0100, 4'b0100, 1, 32'hC1, 1, 0));
    vecs.push_back(mkVec(4'b0100, 32'h00C2_0000, 4'b0100, 0, 1, 0, 4'b0100, 4'b0100, 1, 32'hC2, 1, 0));
    vecs.push_back(mkVec(4'b0101, 32'h00D0_00B0, 4'b0101, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0101, 32'h00D0_00B0, 4'b0101, 0, 1, 0, 4'b0001, 4'b0001, 1, 32'hB0, 1, 0));
    vecs.push_back(mkVec(4'b0100, 32'h00D0_0000, 4'b0100, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0100, 32'h00D0_0000, 4'b0100, 0, 1, 0, 4'b0100, 4'b0100, 1, 32'hD0, 1, 0));
    vecs.push_back(mkVec(4'b0000, 32'h0,         4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0001, 32'h55,        4'b0001, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));
    vecs.push_back(mkVec(4'b0001, 32'h55,        4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0, 32'h0,  1, 0));
    vecs.push_back(mkVec(4'b0001, 32'h55,        4'b0001, 1, 1, 0, 4'b0001, 4'b0000, 0, 32'h0,  1, 0));
    vecs.push_back(mkVec(4'b0001, 32'h55,        4'b0001, 0, 1, 0, 4'b0001, 4'b0001, 1, 32'h55, 1, 0));
    vecs.push_back(mkVec(4'b0000, 32'h0,         4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].full, vecs[i].gnt, vecs[i].rst);
      checkOutput(vecs[i].xGrant, vecs[i].xReady, vecs[i].xWe, vecs[i].xWdata,
                  vecs[i].xBusy, vecs[i].xTimeout, $sformatf("vec%0d", i));
      runCycle("vec", 0);
    end

    // Burst cap: req1 streams 20 bytes with no last flag
    doReset();
    sent = 0; run1 = 0; total = 0; gap = 0; phase = 0;
    for (int c = 0; c < 80 && sent < 20; c++) begin
      applyStimulus(4'b0010, {16'h0, 8'h10 + 8'(sent), 8'h0}, 4'b0000, 1'b0, 1'b1, 1'b0);
      if (uartWe) begin
        if (phase == 0) phase = 1;
        if (phase == 1) run1++;
        if (phase == 2) phase = 3;
        total++;
      end else if (phase == 1) begin
        phase = 2;
        gap = 1;
      end else if (phase == 2) begin
        gap++;
      end
      runCycle("burst", 1);
      if (eWe) sent++;
    end
    checkVal("burstFirstRun", run1, 16);
    checkVal("burstTotal", total, 20);
    checkVal("burstGap", gap, 1);
    checkVal("burstDone", sent, 20);

    // FIFO full for 10 cycles in the middle of a message
    doReset();
    idx = 0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      f = (c >= 3 && c < 13);
      applyStimulus(4'b0001, {24'h0, 8'hF0 + 8'(idx)}, {3'b000, idx == 4}, f, 1'b1, 1'b0);
      if (f) begin
        checkVal("fullNoWe", uartWe, 0);
        checkVal("fullNoReady", reqReady, 0);
        checkVal("fullNoTimeout", timeoutPulse, 0);
        checkVal("fullStillBusy", busy, 1);
      end
      if (c == 13) begin
        checkVal("fullResumeWe", uartWe, 1);
        checkVal("fullResumeData", uartWdata, 32'hF2);
      end
      runCycle("full", 1);
      if (eWe) idx++;
    end
    checkVal("fullDone", idx, 5);

    // Owner goes quiet: timeout releases it and req2 takes over
    doReset();
    applyStimulus(4'b0101, 32'h0070_0030, 4'b0000, 1'b0, 1'b1, 1'b0);
    runCycle("to", 1);
    applyStimulus(4'b0101, 32'h0070_0030, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkVal("toFirstByte", uartWdata, 32'h30);
    runCycle("to", 1);
    pulses = 0; tCycle = 0; gCycle = 0;
    for (int lc = 1; lc <= 14; lc++) begin
      applyStimulus(4'b0100, 32'h0070_0000, 4'b0000, 1'b0, 1'b1, 1'b0);
      if (timeoutPulse) begin
        pulses++;
        tCycle = lc;
      end
      if (grant == 4'b0100 && gCycle == 0) gCycle = lc;
      runCycle("to", 1);
    end
    checkVal("toPulses", pulses, 1);
    checkVal("toPulseCycle", tCycle, 9);
    checkVal("toRegrantCycle", gCycle, 10);

    // Reset in the middle of a req3 message, then clean restart
    doReset();
    applyStimulus(4'b1000, 32'hE000_0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    runCycle("rst", 1);
    applyStimulus(4'b1000, 32'hE000_0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    runCycle("rst", 1);
    applyStimulus(4'b1000, 32'hE100_0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    runCycle("rst", 1);
    applyStimulus(4'b1000, 32'hE200_0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    runCycle("rst", 1);
    applyStimulus(4'b1001, 32'hE000_0011, 4'b0001, 1'b0, 1'b1, 1'b0);
    checkOutput(4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, "rstAfter");
    runCycle("rst", 1);
    applyStimulus(4'b1001, 32'hE000_0011, 4'b0001, 1'b0, 1'b1, 1'b0);
    checkVal("rstPtrZeroGrant", grant, 4'b0001);
    runCycle("rst", 1);
    applyStimulus(4'b1000, 32'hE000_0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    runCycle("rst", 1);
    applyStimulus(4'b1000, 32'hE000_0000, 4'b1000, 1'b0, 1'b1, 1'b0);
    checkVal("rstRestartGrant", grant, 4'b1000);
    checkVal("rstRestartData", uartWdata, 32'hE0);
    runCycle("rst", 1);

    // Randomized traffic against the model; non-owner sources hold valid
    doReset();
    pValid = '0;
    for (int k = 0; k < N; k++) begin
      pData[k] = 8'($urandom);
      pLast[k] = ($urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!(pValid[k] && !(mState == 1 && mOwner == k))) begin
          pValid[k] = ($urandom_range(0, 3) != 0);
        end
        dBus[k*8 +: 8] = pData[k];
      end
      f = ($urandom_range(0, 4) == 0);
      g = ($urandom_range(0, 6) != 0);
      r = ($urandom_range(0, 199) == 0);
      if (r) pValid = '0;
      applyStimulus(pValid, dBus, pLast, f, g, r);
      ownerNow = mOwner;
      runCycle("rand", 1);
      fired = eWe;
      if (fired) begin
        pData[ownerNow] = 8'($urandom);
        pLast[ownerNow] = ($urandom_range(0, 3) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
